// File: rtl/muldiv_pkg.sv
// Shared types for the muldiv arbiter: operation encoding and sequencer states.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_t;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLaunch = 3'd1,
    StBusy   = 3'd2,
    StDrain  = 3'd3,
    StResp   = 3'd4
  } arb_state_e;

  // Division family is the upper half of the encoding.
  function automatic logic is_div_op(logic [2:0] op);
    return op[2];
  endfunction

  // Remainder ops (REM/REMU) have bit 1 set within the division family.
  function automatic logic is_rem_op(logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first valid
// requester at or after ptr_i, wrapping cyclically.
module rr_pick #(
  parameter int unsigned NumReq = 2,
  localparam int unsigned PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [PtrW-1:0]   ptr_i,
  output logic [NumReq-1:0] grant_o
);

  // Scan from the pointer, first valid requester wins.
  always_comb begin
    logic            found;
    logic [PtrW-1:0] idx;
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = PtrW'((32'(ptr_i) + k) % NumReq);
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter/sequencer sharing one iterative muldiv engine between
// NUM_REQ requesters. One operation in flight; flush kills unreturned work.
// Optional macro MULDIV_FASTPATH_EN: divide-family ops with b==0 bypass the
// engine and answer directly from LAUNCH.
module muldiv_arbiter
  import muldiv_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [3*NUM_REQ-1:0]    req_op,
  input  logic [XLEN*NUM_REQ-1:0] req_a,
  input  logic [XLEN*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]         rsp_data,
  output logic                    eng_start,
  output logic [2:0]              eng_op,
  output logic [XLEN-1:0]         eng_a,
  output logic [XLEN-1:0]         eng_b,
  input  logic                    eng_done,
  input  logic [XLEN-1:0]         eng_result
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e      state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0] grant;
  logic [PtrW-1:0]    grant_idx;
  logic               fast_hit;
  logic [XLEN-1:0]    fast_data;

  rr_pick #(
    .NumReq (NUM_REQ)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  // One-hot grant to requester index.
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = PtrW'(i);
    end
  end

`ifdef MULDIV_FASTPATH_EN
  // Divide by zero has an architecturally fixed answer; no engine needed.
  assign fast_hit  = is_div_op(op_q) && (b_q == '0);
  assign fast_data = is_rem_op(op_q) ? a_q : '1;
`else
  assign fast_hit  = 1'b0;
  assign fast_data = '0;
`endif

  // Next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    req_ready  = '0;
    rsp_valid  = '0;
    eng_start  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!flush) begin
          req_ready = grant;
          // grant is only ever set on a valid requester, so this is the handshake
          if (|grant) begin
            op_d     = req_op[32'(grant_idx)*3 +: 3];
            a_d      = req_a[32'(grant_idx)*XLEN +: XLEN];
            b_d      = req_b[32'(grant_idx)*XLEN +: XLEN];
            owner_d  = grant_idx;
            rr_ptr_d = (grant_idx == PtrW'(NUM_REQ - 1)) ? '0 : grant_idx + PtrW'(1);
            state_d  = StLaunch;
          end
        end
      end
      StLaunch: begin
        if (fast_hit) begin
          if (flush) begin
            state_d = StIdle;
          end else begin
            rsp_data_d = fast_data;
            state_d    = StResp;
          end
        end else begin
          // Engine cannot be aborted, so a flush here must still wait for done.
          eng_start = 1'b1;
          state_d   = flush ? StDrain : StBusy;
        end
      end
      StBusy: begin
        if (eng_done && flush) begin
          state_d = StIdle;
        end else if (eng_done) begin
          rsp_data_d = eng_result;
          state_d    = StResp;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (eng_done) state_d = StIdle;
      end
      StResp: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q] || flush) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Keep handshakes quiet while reset is held.
    if (reset) begin
      req_ready = '0;
      rsp_valid = '0;
      eng_start = 1'b0;
    end
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign eng_op   = op_q;
  assign eng_a    = a_q;
  assign eng_b    = b_q;
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Self-checking bench for muldiv_arbiter: vector table of single operations
// plus directed sequences for contention, backpressure, flush and reset.
module tb_muldiv_arbiter;

  localparam int NR = 2;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [3*NR-1:0] req_op;
  logic [XL*NR-1:0] req_a;
  logic [XL*NR-1:0] req_b;
  logic [NR-1:0]   rsp_valid;
  logic [NR-1:0]   rsp_ready;
  logic [XL-1:0]   rsp_data;
  logic            eng_start;
  logic [2:0]      eng_op;
  logic [XL-1:0]   eng_a;
  logic [XL-1:0]   eng_b;
  logic            eng_done   = 1'b0;
  logic [XL-1:0]   eng_result = '0;

  int errors = 0;
  int checks = 0;

  muldiv_arbiter #(
    .NUM_REQ (NR),
    .XLEN    (XL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .eng_start  (eng_start),
    .eng_op     (eng_op),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_done   (eng_done),
    .eng_result (eng_result)
  );

  always #5 clk = ~clk;

  // Reference arithmetic for the engine model (RISC-V M semantics).
  function automatic logic [31:0] eng_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Engine model: latency 4 from the eng_start cycle; keeps counting through
  // reset so a stale done can be presented to the arbiter.
  int          eng_cnt  = 0;
  int          done_cnt = 0;
  int          eng_lat  = 4;
  logic [2:0]  m_op     = '0;
  logic [31:0] m_a      = '0;
  logic [31:0] m_b      = '0;

  always @(negedge clk) begin
    eng_done <= 1'b0;
    if (eng_start) begin
      eng_cnt <= eng_lat;
      m_op    <= eng_op;
      m_a     <= eng_a;
      m_b     <= eng_b;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done   <= 1'b1;
        eng_result <= eng_model(m_op, m_a, m_b);
        done_cnt   <= done_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int idx, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    req_valid[idx]        = 1'b1;
    req_op[3*idx +: 3]    = op;
    req_a[32*idx +: 32]   = a;
    req_b[32*idx +: 32]   = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // One complete transaction on requester idx with all checks along the way.
  task automatic do_op(input string tag, input int idx, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp,
                       input int lat, input logic start);
    int n;
    req_valid = '0;
    drive_req(idx, op, a, b);
    #1;
    check({tag, " ready"}, req_ready, 64'(1 << idx));
    tick();
    req_valid = '0;
    check({tag, " eng_start"}, eng_start, start);
    if (start) begin
      check({tag, " eng_op/a/b"}, {eng_op, eng_a, eng_b[28:0]}, {op, a, b[28:0]});
    end
    n = 1;
    while (rsp_valid == '0 && n < 30) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, lat);
    check({tag, " rsp_valid"}, rsp_valid, 64'(1 << idx));
    check({tag, " rsp_data"}, rsp_data, exp);
    rsp_ready[idx] = 1'b1;
    tick();
    rsp_ready = '0;
    #1;
    check({tag, " rsp_valid drop"}, rsp_valid, 0);
  endtask

  typedef struct {
    int          req;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    logic        start;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int fp_lat;
    logic fp_start;
    int grants[4];
    int maxpop;
    int n;
    int d0;

`ifdef MULDIV_FASTPATH_EN
    fp_lat   = 2;
    fp_start = 1'b0;
`else
    fp_lat   = 6;
    fp_start = 1'b1;
`endif
    vecs[0] = '{0, 3'd0, 32'd6,          32'd7,          32'd42,         6, 1'b1};
    vecs[1] = '{1, 3'd1, 32'h8000_0000,  32'd2,          32'hffff_ffff,  6, 1'b1};
    vecs[2] = '{0, 3'd3, 32'hffff_ffff,  32'd2,          32'd1,          6, 1'b1};
    vecs[3] = '{1, 3'd2, 32'hffff_ffff,  32'hffff_ffff,  32'hffff_ffff,  6, 1'b1};
    vecs[4] = '{0, 3'd4, 32'hffff_ffec,  32'd3,          32'hffff_fffa,  6, 1'b1};
    vecs[5] = '{1, 3'd6, 32'hffff_ffec,  32'd3,          32'hffff_fffe,  6, 1'b1};
    vecs[6] = '{0, 3'd5, 32'd100,        32'd7,          32'd14,         6, 1'b1};
    vecs[7] = '{1, 3'd7, 32'd100,        32'd7,          32'd2,          6, 1'b1};
    vecs[8] = '{0, 3'd6, 32'h1234,       32'd0,          32'h1234,       fp_lat, fp_start};
    vecs[9] = '{1, 3'd5, 32'd5,          32'd0,          32'hffff_ffff,  fp_lat, fp_start};

    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    tick();
    tick();
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset eng_start/op/a/b", {eng_start, eng_op, eng_a, eng_b}, 0);
    reset = 1'b0;
    #1;

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp, vecs[i].lat, vecs[i].start);
    end

    // Contention: both requesters valid, grants alternate from rr_ptr=0.
    do_reset();
    drive_req(0, 3'd0, 32'd3, 32'd10);
    drive_req(1, 3'd0, 32'd4, 32'd10);
    rsp_ready = '1;
    maxpop    = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == '0 && n < 40) begin
        if ($countones(req_ready) > maxpop) maxpop = $countones(req_ready);
        tick();
        n++;
      end
      if ($countones(req_ready) > maxpop) maxpop = $countones(req_ready);
      grants[k] = int'(req_ready);
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 10; k++) tick();
    rsp_ready = '0;
    check("contention grant0", grants[0], 1);
    check("contention grant1", grants[1], 2);
    check("contention grant2", grants[2], 1);
    check("contention grant3", grants[3], 2);
    check("contention one-hot", maxpop, 1);

    // Backpressure on requester 1 while requester 0 keeps asking.
    do_reset();
    drive_req(1, 3'd5, 32'd100, 32'd7);
    #1;
    tick();
    req_valid = '0;
    n = 0;
    while (rsp_valid == '0 && n < 30) begin
      tick();
      n++;
    end
    drive_req(0, 3'd0, 32'd1, 32'd1);
    rsp_ready = 2'b01;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d rsp_valid", k), rsp_valid, 2'b10);
      check($sformatf("bp%0d rsp_data", k), rsp_data, 14);
      check($sformatf("bp%0d req_ready", k), req_ready, 0);
      tick();
    end
    rsp_ready = 2'b10;
    tick();
    rsp_ready = '0;
    #1;
    check("bp release rsp_valid", rsp_valid, 0);
    check("bp next grant", req_ready, 2'b01);
    req_valid = '0;
    #1;

    // Flush two cycles after eng_start: result must vanish.
    do_reset();
    d0 = done_cnt;
    drive_req(0, 3'd5, 32'd100, 32'd7);
    #1;
    tick();
    req_valid = '0;
    check("flush eng_start", eng_start, 1);
    tick();
    tick();
    flush = 1'b1;
    drive_req(1, 3'd0, 32'd2, 32'd2);
    #1;
    check("flush ready gated", req_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      check($sformatf("drain%0d quiet", n), {req_ready, rsp_valid}, 0);
      tick();
      n++;
    end
    check("drain done seen", done_cnt - d0, 1);
    check("drain rsp_valid", rsp_valid, 0);
    check("drain idle grant", req_ready, 2'b10);
    req_valid = '0;
    #1;

    // Flush coinciding with eng_done.
    do_reset();
    d0 = done_cnt;
    drive_req(0, 3'd0, 32'd3, 32'd5);
    #1;
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_req(1, 3'd0, 32'd2, 32'd2);
    #1;
    check("flushdone done seen", done_cnt - d0, 1);
    check("flushdone rsp_valid", rsp_valid, 0);
    check("flushdone idle grant", req_ready, 2'b10);
    req_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    check("flushdone no late rsp", rsp_valid, 0);

    // Reset in BUSY, then a stale eng_done must be ignored.
    do_reset();
    do_op("pre-reset", 0, 3'd0, 32'd6, 32'd7, 32'd42, 6, 1'b1);
    d0 = done_cnt;
    drive_req(0, 3'd3, 32'h0001_0000, 32'h0003_0000);
    #1;
    tick();
    req_valid = '0;
    tick();
    tick();
    reset = 1'b1;
    drive_req(1, 3'd0, 32'd9, 32'd9);
    tick();
    check("rst busy req_ready", req_ready, 0);
    check("rst busy rsp_valid", rsp_valid, 0);
    check("rst busy rsp_data", rsp_data, 0);
    check("rst busy eng regs", {eng_start, eng_op, eng_a, eng_b}, 0);
    req_valid = '0;
    reset     = 1'b0;
    #1;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      tick();
      n++;
    end
    check("stale done seen", done_cnt - d0, 1);
    tick();
    check("stale done ignored", {rsp_valid, eng_start}, 0);
    do_op("post-reset", 1, 3'd0, 32'd6, 32'd7, 32'd42, 6, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
